sys: RTL and testbench
======================

SYS -- requirements
Module: sys

Interface
REQ-001 Parameter MEM_AW, default 12, word-address width of each byte-lane RAM (2^MEM_AW entries, 16 KB total at default).
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset_l  input  1  reset, asynchronous, active-low.
REQ-005 No other ports; observation is by hierarchy only.
REQ-006 Hierarchy SHALL be: instance rv (RV32I core) containing rs1_ram and rs2_ram, each with array ram[0:31] of 32 bits; instances dmem_0..dmem_3, each with array ram[0:2^MEM_AW-1] of 8 bits; dmem_N holds byte lane N (bits 8N+7:8N) of each word.

Function
REQ-007 Single unified memory for instructions and data; word index = addr[MEM_AW+1:2]; higher address bits ignored (aliasing).
REQ-008 Memory reads synchronous, 1-cycle latency; writes on rising edge with per-lane byte enables.
REQ-009 Register file duplicated: every writeback writes the same index/data to rs1_ram and rs2_ram; rs1 read from rs1_ram, rs2 from rs2_ram, both 1-cycle synchronous.
REQ-010 Writes with rd=0 suppressed; ram[0] of both copies preset to 0 externally; x0 always reads 0.
REQ-011 Core is multicycle FSM: FETCH -> DECODE -> EXEC -> (MEM for loads) -> FETCH.
REQ-012 FETCH: drive memory address = pc. DECODE: latch instruction, present rs1/rs2 to register RAMs. EXEC: compute ALU result, branch/jump target, store write, non-load writeback, pc update. MEM: load data extended and written back, pc <= pc+4.
REQ-013 Latency: 3 cycles per ALU/LUI/AUIPC/branch/jump/store instruction, 4 cycles per load.
REQ-014 Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all RV32I OP-IMM and OP instructions.
REQ-015 FENCE, ECALL, EBREAK, CSR and undefined opcodes execute as NOP (pc+4, no writes).
REQ-016 JAL/JALR write pc+4 to rd; JALR target = (rs1+imm) with bit 0 cleared.
REQ-017 Shifts use low 5 bits of shift amount; SRA/SRAI arithmetic; SLT signed, SLTU unsigned; add/sub wrap modulo 2^32.
REQ-018 Byte store writes lane addr[1:0] only, data replicated; halfword store writes lanes {1,0} or {3,2} by addr[1]; addr[0] ignored for halfwords, addr[1:0] ignored for words.
REQ-019 Loads select byte/half by the same rule; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 pc bits [1:0] always 0; misaligned jump/branch targets have low two bits cleared.

Reset
REQ-021 reset_l low: state = FETCH, pc = RESET_PC immediately, no memory or register writes while low or on the release edge.
REQ-022 Reset asserted mid-instruction aborts it; no partial writeback or store completes.
REQ-023 Memory and register-file contents not cleared by reset.
REQ-024 First rising edge after release performs FETCH of RESET_PC.

Verification
REQ-025 Reset hold 2 cycles then release -> first memory read address 0x0; pc 0x4 after 3 cycles.
REQ-026 ADDI x1,x0,5; ADDI x2,x1,7 -> rs1_ram.ram[2] = rs2_ram.ram[2] = 12 after 6 cycles.
REQ-027 x1=0x80; SB x1,3(x0); LB x3,3(x0); LBU x4,3(x0) -> dmem_3.ram[0]=0x80, x3=0xFFFFFF80, x4=0x00000080.
REQ-028 ADDI x0,x0,9 -> ram[0] stays 0 in both copies; JAL x1,+8 at 0x10 -> x1=0x14, next fetch 0x18.
REQ-029 BNE countdown loop of 3 iterations -> exits with counter 0 at expected cycle count (3 per instr).
REQ-030 Assert reset_l during EXEC of SW -> target memory word unchanged, pc=RESET_PC.

Source files
------------

// File: rtl/sys_if.sv
// sys_if: unified memory bus between the rv core and the byte-lane RAMs.
// master drives addr/wdata/be (per-lane write enables), slave returns rdata.
interface sys_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output be,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  be,
    output rdata
  );
endinterface

// File: rtl/sys.sv
// sys: multicycle RV32I core (rv) on a unified memory of four byte-lane RAMs.
// Ports: clk, reset_l (async, active-low). State is observed by hierarchy.

module byte_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] ram [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
    rdata <= ram[addr];
  end
endmodule

module rf_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] ram [0:31];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    rdata <= ram[raddr];
  end
endmodule

module rv_core #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic  clk,
  input  logic  rst_n,
  sys_if.master bus
);
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [31:0] pc;
  logic [31:0] ir;
  logic [1:0]  alo;

  logic [4:0]  ra1, ra2;
  logic [31:0] rs1_d, rs2_d;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  // Duplicated register file: one read port per copy, shared write.
  rf_ram rs1_ram (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_wa),
    .wdata (rf_wd),
    .raddr (ra1),
    .rdata (rs1_d)
  );

  rf_ram rs2_ram (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_wa),
    .wdata (rf_wd),
    .raddr (ra2),
    .rdata (rs2_d)
  );

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign rd  = ir[11:7];

  logic is_lui, is_aui, is_jal, is_jlr;
  logic is_br, is_ld, is_st, is_opi, is_op;

  assign is_lui = (opc == OP_LUI);
  assign is_aui = (opc == OP_AUI);
  assign is_jal = (opc == OP_JAL);
  assign is_jlr = (opc == OP_JLR);
  assign is_br  = (opc == OP_BR);
  assign is_opi = (opc == OP_IMM);
  assign is_op  = (opc == OP_REG);
  // Reserved load/store widths fall through as NOPs.
  assign is_ld  = (opc == OP_LD) &&
                  (f3 != 3'b011) && (f3[2:1] != 2'b11);
  assign is_st  = (opc == OP_ST) && (f3 < 3'd3);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  logic [31:0] alu_b, alu_y;
  logic [4:0]  sh;

  assign alu_b = is_op ? rs2_d : imm_i;
  assign sh    = alu_b[4:0];

  // ir[30] selects SUB (register form only) and SRA/SRAI.
  always_comb begin
    alu_y = '0;
    unique case (f3)
      3'b000: alu_y = (is_op && ir[30]) ? rs1_d - alu_b
                                        : rs1_d + alu_b;
      3'b001: alu_y = rs1_d << sh;
      3'b010: alu_y = {31'b0, $signed(rs1_d) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1_d < alu_b};
      3'b100: alu_y = rs1_d ^ alu_b;
      3'b101: alu_y = ir[30] ? 32'($signed(rs1_d) >>> sh)
                             : rs1_d >> sh;
      3'b110: alu_y = rs1_d | alu_b;
      3'b111: alu_y = rs1_d & alu_b;
    endcase
  end

  logic br_tk;

  always_comb begin
    br_tk = 1'b0;
    unique case (f3)
      3'b000:  br_tk = (rs1_d == rs2_d);
      3'b001:  br_tk = (rs1_d != rs2_d);
      3'b100:  br_tk = $signed(rs1_d) < $signed(rs2_d);
      3'b101:  br_tk = $signed(rs1_d) >= $signed(rs2_d);
      3'b110:  br_tk = rs1_d < rs2_d;
      3'b111:  br_tk = rs1_d >= rs2_d;
      default: br_tk = 1'b0;
    endcase
  end

  logic [31:0] pc4, npc, ea;

  assign pc4 = pc + 32'd4;
  assign ea  = rs1_d + (is_st ? imm_s : imm_i);

  // Loads hold pc here; MEM advances it after the data returns.
  always_comb begin
    npc = pc4;
    unique case (1'b1)
      is_jal:          npc = pc + imm_j;
      is_jlr:          npc = (rs1_d + imm_i) & ~32'h1;
      (is_br && br_tk): npc = pc + imm_b;
      is_ld:           npc = pc;
      default:         npc = pc4;
    endcase
  end

  logic [31:0] ex_wd;
  logic        ex_wr;

  assign ex_wr = is_lui | is_aui | is_jal | is_jlr |
                 is_opi | is_op;

  always_comb begin
    ex_wd = alu_y;
    unique case (1'b1)
      is_lui:            ex_wd = imm_u;
      is_aui:            ex_wd = pc + imm_u;
      (is_jal || is_jlr): ex_wd = pc4;
      default:           ex_wd = alu_y;
    endcase
  end

  logic [31:0] st_wd;
  logic [3:0]  st_be;

  always_comb begin
    st_wd = rs2_d;
    st_be = 4'b1111;
    unique case (f3[1:0])
      2'b00: begin
        st_wd = {4{rs2_d[7:0]}};
        st_be = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        st_wd = {2{rs2_d[15:0]}};
        st_be = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wd = rs2_d;
        st_be = 4'b1111;
      end
    endcase
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_wd;

  assign ld_b = bus.rdata[{alo, 3'b000} +: 8];
  assign ld_h = alo[1] ? bus.rdata[31:16] : bus.rdata[15:0];

  always_comb begin
    ld_wd = bus.rdata;
    unique case (f3)
      3'b000:  ld_wd = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_wd = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_wd = {24'b0, ld_b};
      3'b101:  ld_wd = {16'b0, ld_h};
      default: ld_wd = bus.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH:  state_nx = DECODE;
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = is_ld ? MEM : FETCH;
      MEM:    state_nx = FETCH;
    endcase
  end

  // In DECODE the instruction is still on the memory output, so the
  // register RAMs are addressed straight from it.
  always_comb begin
    bus.addr  = pc;
    bus.wdata = st_wd;
    bus.be    = 4'b0000;
    ra1       = ir[19:15];
    ra2       = ir[24:20];
    rf_we     = 1'b0;
    rf_wa     = rd;
    rf_wd     = ex_wd;
    unique case (state)
      FETCH: bus.addr = pc;
      DECODE: begin
        ra1 = bus.rdata[19:15];
        ra2 = bus.rdata[24:20];
      end
      EXEC: begin
        bus.addr = ea;
        if (is_st) bus.be = st_be;
        rf_we = ex_wr && (rd != 5'd0);
      end
      MEM: begin
        rf_we = (rd != 5'd0);
        rf_wd = ld_wd;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC & 32'hFFFF_FFFC;
      ir  <= '0;
      alo <= '0;
    end else begin
      if (state == DECODE) ir <= bus.rdata;
      if (state == EXEC) begin
        pc  <= npc & 32'hFFFF_FFFC;
        alo <= ea[1:0];
      end
      if (state == MEM) pc <= pc4;
    end
  end
endmodule

module sys #(
  parameter int          MEM_AW   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic reset_l
);
  sys_if bus ();

  rv_core #(
    .RESET_PC (RESET_PC)
  ) rv (
    .clk   (clk),
    .rst_n (reset_l),
    .bus   (bus)
  );

  // Upper address bits alias; byte offset is handled by the lane enables.
  logic [MEM_AW-1:0] widx;
  logic              unused_addr;

  assign widx        = bus.addr[MEM_AW+1:2];
  assign unused_addr = ^{bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  byte_ram #(.AW(MEM_AW)) dmem_0 (
    .clk   (clk),
    .we    (bus.be[0]),
    .addr  (widx),
    .wdata (bus.wdata[7:0]),
    .rdata (bus.rdata[7:0])
  );

  byte_ram #(.AW(MEM_AW)) dmem_1 (
    .clk   (clk),
    .we    (bus.be[1]),
    .addr  (widx),
    .wdata (bus.wdata[15:8]),
    .rdata (bus.rdata[15:8])
  );

  byte_ram #(.AW(MEM_AW)) dmem_2 (
    .clk   (clk),
    .we    (bus.be[2]),
    .addr  (widx),
    .wdata (bus.wdata[23:16]),
    .rdata (bus.rdata[23:16])
  );

  byte_ram #(.AW(MEM_AW)) dmem_3 (
    .clk   (clk),
    .we    (bus.be[3]),
    .addr  (widx),
    .wdata (bus.wdata[31:24]),
    .rdata (bus.rdata[31:24])
  );
endmodule

// File: tb/tb_sys.sv
// tb_sys: directed programs loaded by hierarchy into sys, checked against
// hand-computed register, memory and pc values.
module tb_sys;
  logic clk;
  logic reset_l;

  int n_cmp;
  int n_bad;

  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [31:0] NOP = 32'h0000_0013;

  sys dut (
    .clk     (clk),
    .reset_l (reset_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input int imm, input int rs1,
                                     input int f3, input int rd,
                                     input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] er(input int f7, input int rs2,
                                     input int rs1, input int f3,
                                     input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] es(input int imm, input int rs2,
                                     input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] eb(input int imm, input int rs2,
                                     input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3),
            v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] ej(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] eu(input int imm, input int rd,
                                     input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[19:0], 5'(rd), op};
  endfunction

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    logic [11:0] i;
    i = a[13:2];
    dut.dmem_0.ram[i] = d[7:0];
    dut.dmem_1.ram[i] = d[15:8];
    dut.dmem_2.ram[i] = d[23:16];
    dut.dmem_3.ram[i] = d[31:24];
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [11:0] i;
    i = a[13:2];
    return {dut.dmem_3.ram[i], dut.dmem_2.ram[i],
            dut.dmem_1.ram[i], dut.dmem_0.ram[i]};
  endfunction

  function automatic logic [31:0] x1r(input int r);
    return dut.rv.rs1_ram.ram[r];
  endfunction

  function automatic logic [31:0] x2r(input int r);
    return dut.rv.rs2_ram.ram[r];
  endfunction

  task automatic hold_reset();
    reset_l = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      dut.rv.rs1_ram.ram[i] = '0;
      dut.rv.rs2_ram.ram[i] = '0;
    end
    for (int i = 0; i < 64; i++) wr_word(32'(i * 4), NOP);
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_l = 1'b0;

    // reset, first fetch, dependent ADDIs
    hold_reset();
    wr_word(32'h00, ei(5, 0, 0, 1, OPI));
    wr_word(32'h04, ei(7, 1, 0, 2, OPI));
    check("rst_pc", dut.rv.pc, 32'h0);
    check("rst_state", 32'(dut.rv.state), 32'd0);
    release_rst();
    check("first_addr", dut.bus.addr, 32'h0);
    step(3);
    check("pc_after3", dut.rv.pc, 32'h4);
    check("x1_5", x1r(1), 32'd5);
    step(3);
    check("x2_rs1", x1r(2), 32'd12);
    check("x2_rs2", x2r(2), 32'd12);

    // byte store and signed/unsigned byte loads
    hold_reset();
    wr_word(32'h00, ei(32'h80, 0, 0, 1, OPI));
    wr_word(32'h04, es(3, 1, 0, 0));
    wr_word(32'h08, ei(3, 0, 0, 3, LD));
    wr_word(32'h0C, ei(3, 0, 4, 4, LD));
    release_rst();
    step(6);
    check("sb_lane3", 32'(dut.dmem_3.ram[0]), 32'h80);
    check("sb_word", rd_word(32'h0), 32'h8000_0093);
    step(4);
    check("lb_x3", x1r(3), 32'hFFFF_FF80);
    step(4);
    check("lbu_x4", x1r(4), 32'h0000_0080);

    // word/half stores and loads, aliasing
    hold_reset();
    wr_word(32'h104, 32'h1122_3344);
    wr_word(32'h00, eu(32'h12345, 5, LUI));
    wr_word(32'h04, ei(32'h678, 5, 0, 5, OPI));
    wr_word(32'h08, es(32'h100, 5, 0, 2));
    wr_word(32'h0C, ei(32'h102, 0, 2, 6, LD));
    wr_word(32'h10, ei(32'h102, 0, 1, 7, LD));
    wr_word(32'h14, ei(-1, 0, 0, 8, OPI));
    wr_word(32'h18, es(32'h106, 8, 0, 1));
    wr_word(32'h1C, ei(32'h107, 0, 1, 9, LD));
    wr_word(32'h20, ei(32'h106, 0, 5, 10, LD));
    wr_word(32'h24, ei(32'h104, 0, 4, 11, LD));
    wr_word(32'h28, ei(32'h105, 0, 0, 12, LD));
    wr_word(32'h2C, eu(32'h4, 14, LUI));
    wr_word(32'h30, ei(32'h100, 14, 2, 13, LD));
    release_rst();
    step(6);
    check("lui_addi", x1r(5), 32'h1234_5678);
    step(40);
    check("sw_mem", rd_word(32'h100), 32'h1234_5678);
    check("lw_x6", x1r(6), 32'h1234_5678);
    check("lh_x7", x1r(7), 32'h0000_1234);
    check("sh_mem", rd_word(32'h104), 32'hFFFF_3344);
    check("lh_x9", x1r(9), 32'hFFFF_FFFF);
    check("lhu_x10", x1r(10), 32'h0000_FFFF);
    check("lbu_x11", x1r(11), 32'h0000_0044);
    check("lb_x12", x1r(12), 32'h0000_0033);
    check("alias_x13", x2r(13), 32'h1234_5678);

    // x0 stays zero, JAL link and target
    hold_reset();
    wr_word(32'h00, ei(9, 0, 0, 0, OPI));
    wr_word(32'h10, ej(8, 1));
    wr_word(32'h14, ei(1, 0, 0, 2, OPI));
    wr_word(32'h18, ei(2, 0, 0, 3, OPI));
    release_rst();
    step(3);
    check("x0_rs1", x1r(0), 32'h0);
    check("x0_rs2", x2r(0), 32'h0);
    step(12);
    check("jal_x1", x1r(1), 32'h14);
    check("jal_pc", dut.rv.pc, 32'h18);
    check("jal_fetch", dut.bus.addr, 32'h18);
    step(3);
    check("jal_x3", x1r(3), 32'd2);
    check("jal_skip", x1r(2), 32'd0);

    // BNE countdown loop
    hold_reset();
    wr_word(32'h00, ei(3, 0, 0, 1, OPI));
    wr_word(32'h04, ei(-1, 1, 0, 1, OPI));
    wr_word(32'h08, eb(-4, 0, 1, 1));
    wr_word(32'h0C, ei(7, 0, 0, 2, OPI));
    release_rst();
    step(21);
    check("loop_x1", x1r(1), 32'd0);
    check("loop_pc", dut.rv.pc, 32'h0C);
    step(3);
    check("loop_exit", x1r(2), 32'd7);

    // ALU ops, AUIPC, JALR alignment, ECALL as NOP
    hold_reset();
    wr_word(32'h00, ei(-8, 0, 0, 1, OPI));
    wr_word(32'h04, ei(33, 0, 0, 2, OPI));
    wr_word(32'h08, er(32'h20, 2, 1, 5, 3));
    wr_word(32'h0C, er(0, 2, 1, 5, 4));
    wr_word(32'h10, er(0, 2, 1, 2, 5));
    wr_word(32'h14, er(0, 2, 1, 3, 6));
    wr_word(32'h18, er(32'h20, 1, 2, 0, 7));
    wr_word(32'h1C, er(0, 2, 2, 1, 8));
    wr_word(32'h20, ei(32'hF, 1, 4, 9, OPI));
    wr_word(32'h24, eu(1, 10, AUI));
    wr_word(32'h28, ei(18, 2, 0, 11, JLR));
    wr_word(32'h2C, ei(1, 0, 0, 12, OPI));
    wr_word(32'h30, 32'h0000_0073);
    wr_word(32'h34, ei(32'h402, 1, 5, 13, OPI));
    release_rst();
    step(33);
    check("sra", x1r(3), 32'hFFFF_FFFC);
    check("srl", x1r(4), 32'h7FFF_FFFC);
    check("slt", x1r(5), 32'd1);
    check("sltu", x1r(6), 32'd0);
    check("sub", x1r(7), 32'd41);
    check("sll", x1r(8), 32'd66);
    check("xori", x1r(9), 32'hFFFF_FFF7);
    check("auipc", x1r(10), 32'h0000_1024);
    check("jalr_link", x1r(11), 32'h2C);
    check("jalr_pc", dut.rv.pc, 32'h30);
    step(6);
    check("srai", x2r(13), 32'hFFFF_FFFE);
    check("jalr_skip", x1r(12), 32'd0);
    check("ecall_pc", dut.rv.pc, 32'h38);

    // reset during EXEC of SW aborts the store
    hold_reset();
    wr_word(32'h200, 32'hDEAD_BEEF);
    wr_word(32'h00, ei(32'h55, 0, 0, 1, OPI));
    wr_word(32'h04, es(32'h200, 1, 0, 2));
    release_rst();
    step(5);
    check("sw_in_exec", 32'(dut.rv.state), 32'd2);
    reset_l = 1'b0;
    #1;
    check("abort_pc", dut.rv.pc, 32'h0);
    check("abort_state", 32'(dut.rv.state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_mem", rd_word(32'h200), 32'hDEAD_BEEF);
    check("keep_x1", x1r(1), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
